// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier sequencer states and the default operand width.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  localparam int MULT_SIZE_DEFAULT = 4;

endpackage

// File: rtl/ripple_adder.sv
// Parameterised ripple-carry adder; the carry-out becomes bit WIDTH of the sum.
module ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/multiplier_unit.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock,
// full 2*SIZE-bit product plus an overflow flag for results wider than SIZE bits.
module multiplier_unit
  import alu_pkg::*;
#(
  parameter int SIZE = MULT_SIZE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic              over,
  output logic [2*SIZE-1:0] c
);

  localparam int CNT_W = $clog2(SIZE + 1);

  mult_state_e state_q, state_d;

  // The 2*SIZE accumulator is {acc_q, mplier_q}: product bits shift into the
  // multiplier register as its consumed LSBs shift out.
  logic [SIZE-1:0]   mcand_q, mcand_d;
  logic [SIZE-1:0]   mplier_q, mplier_d;
  logic [SIZE-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*SIZE-1:0] c_q, c_d;
  logic              over_q, over_d;

  logic [SIZE-1:0]   addend;
  logic [SIZE-1:0]   sum;
  logic              carry;
  logic              last_iter;
  logic              accept;

  assign addend    = mplier_q[0] ? mcand_q : '0;
  assign last_iter = (cnt_q == CNT_W'(SIZE - 1));
  assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  ripple_adder #(.WIDTH(SIZE)) u_adder (
    .a    (acc_q),
    .b    (addend),
    .sum  (sum),
    .cout (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      c_q      <= '0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      over_q   <= over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_iter) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result registers load on the final iteration so c/over are valid while done is high.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    over_d   = over_q;
    if (accept) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (state_q == ST_RUN) begin
      acc_d    = {carry, sum[SIZE-1:1]};
      mplier_d = {sum[0], mplier_q[SIZE-1:1]};
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_iter) begin
        c_d    = {carry, sum, mplier_q[SIZE-1:1]};
        over_d = |{carry, sum[SIZE-1:1]};
      end
    end
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  assign c    = c_q;
  assign over = over_q;

endmodule

// File: tb/tb_multiplier_unit.sv
// Self-checking bench: SIZE=4 vector table and corner sequences, SIZE=8 randomized
// back-to-back stream checked against plain a*b arithmetic.
module tb_multiplier_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4, over4;
  logic [7:0] c4;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, over8;
  logic [15:0] c8;

  int n_cmp = 0;
  int n_err = 0;

  multiplier_unit #(.SIZE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .over(over4), .c(c4)
  );

  multiplier_unit #(.SIZE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .over(over8), .c(c8)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_done_excl4", 32'(busy4 && done4), 32'd0);
      check("busy_done_excl8", 32'(busy8 && done8), 32'd0);
    end
  end

  // Issue one SIZE=4 operation from IDLE and observe 12 cycles after acceptance.
  task automatic do_op4(input logic [3:0] ta, input logic [3:0] tb_,
                        output logic [7:0] rc, output logic ro,
                        output int lat, output int nbusy, output int ndone);
    rc = '0; ro = 1'b0; lat = 0; nbusy = 0; ndone = 0;
    a4 = ta; b4 = tb_; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (busy4) nbusy++;
      if (done4) begin
        ndone++;
        if (lat == 0) begin
          lat = k;
          rc  = c4;
          ro  = over4;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] c;
    logic       over;
  } vec_t;

  vec_t tbl[7];

  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [15:0] expq[$];

  initial begin
    logic [7:0]  rc;
    logic        ro;
    int          lat, nbusy, ndone;
    logic [15:0] e;
    int          n_ops;

    tbl[0] = '{4'hF, 4'd0,  8'h00, 1'b0};
    tbl[1] = '{4'hF, 4'd1,  8'h0F, 1'b0};
    tbl[2] = '{4'hF, 4'd2,  8'h1E, 1'b1};
    tbl[3] = '{4'hF, 4'd3,  8'h2D, 1'b1};
    tbl[4] = '{4'hF, 4'd4,  8'h3C, 1'b1};
    tbl[5] = '{4'hF, 4'd9,  8'h87, 1'b1};
    tbl[6] = '{4'hF, 4'd15, 8'hE1, 1'b1};

    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    #12;
    check("rst_c4",    32'(c4),    32'd0);
    check("rst_over4", 32'(over4), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_c8",    32'(c8),    32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table: product, flag, latency, busy width and single done pulse.
    for (int i = 0; i < 7; i++) begin
      do_op4(tbl[i].a, tbl[i].b, rc, ro, lat, nbusy, ndone);
      $display("op4 %0d*%0d -> c=%02h over=%0d lat=%0d busy=%0d done=%0d",
               tbl[i].a, tbl[i].b, rc, ro, lat, nbusy, ndone);
      check("vec_c",     32'(rc),   32'(tbl[i].c));
      check("vec_over",  32'(ro),   32'(tbl[i].over));
      check("vec_lat",   32'(lat),  32'd5);
      check("vec_busy",  32'(nbusy), 32'd4);
      check("vec_ndone", 32'(ndone), 32'd1);
    end

    // Second start during RUN ignored; operand changes after acceptance ignored.
    a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 4'd3; b4 = 4'd5;
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 4'd7; b4 = 4'd2;
    ndone = 0; lat = 0; rc = '0; ro = 1'b0;
    for (int k = 3; k <= 14; k++) begin
      if (done4) begin
        ndone++;
        if (lat == 0) begin lat = k; rc = c4; ro = over4; end
      end
      @(posedge clk); #1;
    end
    $display("op4 ignore-start 15*15 -> c=%02h over=%0d lat=%0d done=%0d", rc, ro, lat, ndone);
    check("ign_c",     32'(rc),    32'hE1);
    check("ign_over",  32'(ro),    32'd1);
    check("ign_lat",   32'(lat),   32'd5);
    check("ign_ndone", 32'(ndone), 32'd1);

    // Asynchronous reset in the middle of RUN.
    a4 = 4'd6; b4 = 4'd7; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_c4",    32'(c4),    32'd0);
    check("midrst_over4", 32'(over4), 32'd0);
    check("midrst_busy4", 32'(busy4), 32'd0);
    check("midrst_done4", 32'(done4), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      if (done4) ndone++;
      @(posedge clk); #1;
    end
    $display("op4 reset-abort -> done pulses after release=%0d c=%02h", ndone, c4);
    check("midrst_nodone", 32'(ndone), 32'd0);
    check("midrst_hold_c", 32'(c4),    32'd0);

    do_op4(4'd6, 4'd7, rc, ro, lat, nbusy, ndone);
    $display("op4 6*7 -> c=%02h over=%0d lat=%0d", rc, ro, lat);
    check("recover_c",    32'(rc),  32'h2A);
    check("recover_over", 32'(ro),  32'd1);
    check("recover_lat",  32'(lat), 32'd5);

    // SIZE=8 back-to-back stream: start held high, junk operands between acceptances.
    qa.push_back(8'd0);   qb.push_back(8'd0);
    qa.push_back(8'd255); qb.push_back(8'd255);
    qa.push_back(8'd255); qb.push_back(8'd1);
    qa.push_back(8'd1);   qb.push_back(8'd255);
    qa.push_back(8'd16);  qb.push_back(8'd16);
    qa.push_back(8'd15);  qb.push_back(8'd17);
    qa.push_back(8'd0);   qb.push_back(8'd255);
    for (int i = 0; i < 1000; i++) begin
      qa.push_back(8'($urandom));
      qb.push_back(8'($urandom));
    end
    n_ops = qa.size();

    for (int n = 0; n <= n_ops * 9; n++) begin
      check("busy8_phase", 32'(busy8), 32'((n % 9) != 0));
      if ((n % 9) == 0) begin
        if (n > 0) begin
          check("done8_pulse", 32'(done8), 32'd1);
          e = expq.pop_front();
          $display("op8 #%0d -> c=%04h over=%0d (model %04h)", n / 9 - 1, c8, over8, e);
          check("stream_c",    32'(c8),    32'(e));
          check("stream_over", 32'(over8), 32'(e > 16'd255));
        end else begin
          check("done8_idle", 32'(done8), 32'd0);
        end
        if ((n / 9) < n_ops) begin
          start8 = 1'b1;
          a8 = qa[n / 9];
          b8 = qb[n / 9];
          expq.push_back(16'(a8) * 16'(b8));
        end else begin
          start8 = 1'b0;
        end
      end else begin
        check("done8_quiet", 32'(done8), 32'd0);
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    check("idle8_after", 32'(busy8 || done8), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
